// File: rtl/seq_stream_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first on w, with repetitions and idle gaps.
// Optional build macro SEQ_STREAM_GEN_LFSR_EN substitutes an LFSR value when a zero pattern is started.
module seq_stream_gen #(
  parameter int PAT_W   = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             w,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  logic [1:0]       state_r, state_s;
  logic [PAT_W-1:0] pat_r, pat_s, pat_sel_s;
  logic [LEN_W-1:0] len_r, len_s, len_eff_s;
  logic [REP_W-1:0] reps_r, reps_s, reps_eff_s;
  logic [LEN_W-1:0] bit_r, bit_s;
  logic [REP_W-1:0] rep_r, rep_s;
  logic [GAP_W-1:0] gap_r, gap_s;
  logic             w_r, w_s, valid_r, valid_s, busy_r, busy_s, done_r, done_s;

`ifdef SEQ_STREAM_GEN_LFSR_EN
  localparam logic [PAT_W-1:0] LFSR_TAPS = PAT_W'(8'hB8);
  logic [PAT_W-1:0] lfsr_r;

  function automatic logic parity(input logic [PAT_W-1:0] v);
    return ^v;
  endfunction

  // Fibonacci LFSR stepped once per accepted start; all-ones seed keeps it nonzero
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= {PAT_W{1'b1}};
    end else if (state_r == ST_IDLE && start) begin
      lfsr_r <= {lfsr_r[PAT_W-2:0], parity(lfsr_r & LFSR_TAPS)};
    end
  end

  assign pat_sel_s = (pattern == {PAT_W{1'b0}}) ? lfsr_r : pattern;
`else
  assign pat_sel_s = pattern;
`endif

  assign len_eff_s  = (len == {LEN_W{1'b0}} || len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
  assign reps_eff_s = (reps == {REP_W{1'b0}}) ? REP_W'(1'b1) : reps;

  // Next-state and next-output logic; outputs are registered one edge later
  always_comb begin
    state_s = state_r;
    pat_s   = pat_r;
    len_s   = len_r;
    reps_s  = reps_r;
    bit_s   = bit_r;
    rep_s   = rep_r;
    gap_s   = gap_r;
    w_s     = 1'b0;
    valid_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          pat_s   = pat_sel_s;
          len_s   = len_eff_s;
          reps_s  = reps_eff_s;
          bit_s   = {LEN_W{1'b0}};
          rep_s   = REP_W'(1'b1);
          gap_s   = {GAP_W{1'b0}};
          state_s = ST_SHIFT;
          w_s     = pat_sel_s[IDX_W'(len_eff_s - LEN_W'(1))];
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_s = ST_IDLE;
          bit_s   = {LEN_W{1'b0}};
          rep_s   = {REP_W{1'b0}};
          gap_s   = {GAP_W{1'b0}};
        end else if (bit_r == len_r - LEN_W'(1)) begin
          bit_s = {LEN_W{1'b0}};
          if (rep_r == reps_r) begin
            state_s = ST_DONE;
            rep_s   = {REP_W{1'b0}};
            done_s  = 1'b1;
          end else begin
            rep_s = rep_r + REP_W'(1);
            if (GAP_CYC > 0) begin
              state_s = ST_GAP;
              gap_s   = {GAP_W{1'b0}};
              busy_s  = 1'b1;
            end else begin
              w_s     = pat_r[IDX_W'(len_r - LEN_W'(1))];
              valid_s = 1'b1;
              busy_s  = 1'b1;
            end
          end
        end else begin
          // index of bit k+1 is L-1-(k+1)
          bit_s   = bit_r + LEN_W'(1);
          w_s     = pat_r[IDX_W'(len_r - LEN_W'(2) - bit_r)];
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_s = ST_IDLE;
          bit_s   = {LEN_W{1'b0}};
          rep_s   = {REP_W{1'b0}};
          gap_s   = {GAP_W{1'b0}};
        end else if (gap_r == GAP_W'(GAP_LAST)) begin
          state_s = ST_SHIFT;
          gap_s   = {GAP_W{1'b0}};
          bit_s   = {LEN_W{1'b0}};
          w_s     = pat_r[IDX_W'(len_r - LEN_W'(1))];
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end else begin
          gap_s  = gap_r + GAP_W'(1);
          busy_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        bit_s   = {LEN_W{1'b0}};
        rep_s   = {REP_W{1'b0}};
        gap_s   = {GAP_W{1'b0}};
      end
    endcase
  end

  // State, latched transmission parameters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      pat_r   <= {PAT_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      reps_r  <= {REP_W{1'b0}};
      bit_r   <= {LEN_W{1'b0}};
      rep_r   <= {REP_W{1'b0}};
      gap_r   <= {GAP_W{1'b0}};
      w_r     <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pat_r   <= pat_s;
      len_r   <= len_s;
      reps_r  <= reps_s;
      bit_r   <= bit_s;
      rep_r   <= rep_s;
      gap_r   <= gap_s;
      w_r     <= w_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign w     = w_r;
  assign valid = valid_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_seq_stream_gen.sv
// Directed bench for seq_stream_gen: a vector table of single-cycle stimulus/expectation records,
// followed by hand-written multi-cycle sequences for re-start, abort and reset interruptions.
module tb_seq_stream_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] len = 4'd0;
  logic [3:0] reps = 4'd0;
  logic       w, valid, busy, done;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic       start;
    logic       abort;
    logic [7:0] pat;
    logic [3:0] len;
    logic [3:0] reps;
    logic [3:0] exp;   // {w, valid, busy, done} after the edge
    string      name;
  } vec_t;

  vec_t vecs[$];

  seq_stream_gen #(.PAT_W(8), .LEN_W(4), .REP_W(4), .GAP_CYC(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .len(len), .reps(reps),
    .w(w), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock once, then compare outputs 1ns after the edge
  task automatic cyc(input logic s, input logic a, input logic r, input logic [7:0] p,
                     input logic [3:0] l, input logic [3:0] rp, input logic [3:0] e, input string nm);
    start = s; abort = a; reset = r; pattern = p; len = l; reps = rp;
    @(posedge clk);
    #1;
    checks++;
    if ({w, valid, busy, done} !== e)
      $display("FAIL %s: w/valid/busy/done got %b%b%b%b expected %b", nm, w, valid, busy, done, e);
    else
      passed++;
  endtask

  task automatic add(input logic s, input logic a, input logic [7:0] p, input logic [3:0] l,
                     input logic [3:0] rp, input logic [3:0] e, input string nm);
    vec_t v;
    v.start = s; v.abort = a; v.pat = p; v.len = l; v.reps = rp; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  // One burst of n pattern bits, expected stream bits[n-1] first; start/abort only on the first cycle
  task automatic add_bits(input logic s, input logic a, input logic [7:0] p, input logic [3:0] l,
                          input logic [3:0] rp, input logic [7:0] bits, input int n, input string nm);
    for (int i = 0; i < n; i++)
      add((i == 0) ? s : 1'b0, (i == 0) ? a : 1'b0, p, l, rp, {bits[n-1-i], 3'b110}, nm);
  endtask

  task automatic add_end(input string nm);
    add(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'b0001, {nm, "_done"});
    add(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'b0000, {nm, "_idle"});
  endtask

  task automatic add_gap(input string nm);
    add(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'b0010, {nm, "_gap"});
    add(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'b0010, {nm, "_gap"});
  endtask

  logic [7:0] b3 = 8'b1011_0011;

  initial begin
    // zero pattern must be the first start after reset so the LFSR build sends its seed
`ifdef SEQ_STREAM_GEN_LFSR_EN
    add_bits(1'b1, 1'b0, 8'h00, 4'd8, 4'd1, 8'hFF, 8, "zero_pat_lfsr");
`else
    add_bits(1'b1, 1'b0, 8'h00, 4'd4, 4'd1, 8'h00, 4, "zero_pat");
`endif
    add_end("zero_pat");
    add_bits(1'b1, 1'b0, 8'b1011_0011, 4'd8, 4'd1, 8'b1011_0011, 8, "t1_bit");
    add_end("t1");
    add_bits(1'b1, 1'b0, 8'h0B, 4'd4, 4'd3, 8'b0000_1011, 4, "t2_rep1");
    add_gap("t2a");
    add_bits(1'b0, 1'b0, 8'hFF, 4'd2, 4'd1, 8'b0000_1011, 4, "t2_rep2");
    add_gap("t2b");
    add_bits(1'b0, 1'b0, 8'h00, 4'd7, 4'd9, 8'b0000_1011, 4, "t2_rep3");
    add_end("t2");
    add_bits(1'b1, 1'b0, 8'hF0, 4'd0, 4'd0, 8'b1111_0000, 8, "len0_reps0");
    add_end("len0");
    add_bits(1'b1, 1'b0, 8'h96, 4'd12, 4'd1, 8'b1001_0110, 8, "len_over");
    add_end("len_over");
    add_bits(1'b1, 1'b1, 8'h05, 4'd3, 4'd1, 8'b0000_0101, 3, "start_abort");
    add_end("start_abort");
    add_bits(1'b1, 1'b0, 8'h01, 4'd1, 4'd2, 8'b0000_0001, 1, "len1_r1");
    add_gap("len1");
    add_bits(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 8'b0000_0001, 1, "len1_r2");
    add_end("len1");

    cyc(1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 4'b0000, "reset_a");
    cyc(1'b1, 1'b1, 1'b1, 8'hFF, 4'd8, 4'd1, 4'b0000, "reset_prio");

    for (int i = 0; i < vecs.size(); i++)
      cyc(vecs[i].start, vecs[i].abort, 1'b0, vecs[i].pat, vecs[i].len, vecs[i].reps,
          vecs[i].exp, vecs[i].name);

    // second start during the 3rd bit with a different pattern, then start during DONE
    cyc(1'b1, 1'b0, 1'b0, b3, 4'd8, 4'd1, {b3[7], 3'b110}, "restart_b0");
    cyc(1'b0, 1'b0, 1'b0, b3, 4'd8, 4'd1, {b3[6], 3'b110}, "restart_b1");
    cyc(1'b0, 1'b0, 1'b0, b3, 4'd8, 4'd1, {b3[5], 3'b110}, "restart_b2");
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 4'd4, 4'd2, {b3[4], 3'b110}, "restart_b3");
    for (int k = 3; k >= 0; k--)
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd4, 4'd2, {b3[k], 3'b110}, "restart_tail");
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd4, 4'd2, 4'b0001, "restart_done");
    cyc(1'b1, 1'b0, 1'b0, 8'hFF, 4'd8, 4'd1, 4'b0000, "start_in_done");
    cyc(1'b0, 1'b0, 1'b0, 8'hFF, 4'd8, 4'd1, 4'b0000, "no_second_tx");
    cyc(1'b0, 1'b0, 1'b0, 8'hFF, 4'd8, 4'd1, 4'b0000, "no_second_tx");

    // abort while bit 5 is on the line
    cyc(1'b1, 1'b0, 1'b0, b3, 4'd8, 4'd1, {b3[7], 3'b110}, "abort_b0");
    for (int k = 6; k >= 2; k--)
      cyc(1'b0, 1'b0, 1'b0, b3, 4'd8, 4'd1, {b3[k], 3'b110}, "abort_pre");
    cyc(1'b0, 1'b1, 1'b0, b3, 4'd8, 4'd1, 4'b0000, "abort_edge");
    for (int k = 0; k < 4; k++)
      cyc(1'b0, 1'b0, 1'b0, b3, 4'd8, 4'd1, 4'b0000, "abort_no_done");

    // reset in the first gap, then a clean transmission from bit 0
    cyc(1'b1, 1'b0, 1'b0, 8'h0B, 4'd4, 4'd3, 4'b1110, "rst_gap_b0");
    cyc(1'b0, 1'b0, 1'b0, 8'h0B, 4'd4, 4'd3, 4'b0110, "rst_gap_b1");
    cyc(1'b0, 1'b0, 1'b0, 8'h0B, 4'd4, 4'd3, 4'b1110, "rst_gap_b2");
    cyc(1'b0, 1'b0, 1'b0, 8'h0B, 4'd4, 4'd3, 4'b1110, "rst_gap_b3");
    cyc(1'b0, 1'b0, 1'b0, 8'h0B, 4'd4, 4'd3, 4'b0010, "rst_gap_g0");
    cyc(1'b0, 1'b0, 1'b1, 8'h0B, 4'd4, 4'd3, 4'b0000, "rst_gap_edge");
    cyc(1'b0, 1'b0, 1'b0, 8'h0B, 4'd4, 4'd3, 4'b0000, "rst_gap_idle");
    cyc(1'b0, 1'b0, 1'b0, 8'h0B, 4'd4, 4'd3, 4'b0000, "rst_gap_idle");
    cyc(1'b1, 1'b0, 1'b0, 8'hC5, 4'd8, 4'd1, 4'b1110, "fresh_b0");
    cyc(1'b0, 1'b0, 1'b0, 8'hC5, 4'd8, 4'd1, 4'b1110, "fresh_b1");
    cyc(1'b0, 1'b0, 1'b0, 8'hC5, 4'd8, 4'd1, 4'b0110, "fresh_b2");
    cyc(1'b0, 1'b0, 1'b0, 8'hC5, 4'd8, 4'd1, 4'b0110, "fresh_b3");
    cyc(1'b0, 1'b0, 1'b0, 8'hC5, 4'd8, 4'd1, 4'b0110, "fresh_b4");
    cyc(1'b0, 1'b0, 1'b0, 8'hC5, 4'd8, 4'd1, 4'b1110, "fresh_b5");
    cyc(1'b0, 1'b0, 1'b0, 8'hC5, 4'd8, 4'd1, 4'b0110, "fresh_b6");
    cyc(1'b0, 1'b0, 1'b0, 8'hC5, 4'd8, 4'd1, 4'b1110, "fresh_b7");
    cyc(1'b0, 1'b0, 1'b0, 8'hC5, 4'd8, 4'd1, 4'b0001, "fresh_done");
    cyc(1'b0, 1'b0, 1'b0, 8'hC5, 4'd8, 4'd1, 4'b0000, "fresh_idle");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
